// File: rtl/analyser_pkg.sv
// -----------------------------------------------------------------------------
// analyser_pkg
//   Shared types for the pitch/volume analyser.
//   - pitch_e        : band code reported on the pitch output
//   - classify_pitch : maps a measured period (in samples) onto a pitch band
// -----------------------------------------------------------------------------
package analyser_pkg;

    typedef enum logic [1:0] {
        PITCH_NONE = 2'b00,
        PITCH_LOW  = 2'b10,
        PITCH_MID  = 2'b01,
        PITCH_HIGH = 2'b11
    } pitch_e;

    // Long periods are low notes. A period equal to low_th still counts as MID.
    function automatic pitch_e classify_pitch(input int period,
                                              input int low_th,
                                              input int mid_th);
        if (period > low_th) begin
            return PITCH_LOW;
        end else if (period >= mid_th) begin
            return PITCH_MID;
        end
        return PITCH_HIGH;
    endfunction

endpackage

// File: rtl/abs_sat.sv
// -----------------------------------------------------------------------------
// abs_sat
//   Combinational saturating absolute value of a two's-complement sample.
//   The most-negative code has no positive counterpart, so it maps to the
//   largest positive value instead of wrapping back to itself.
//   Ports:
//     sample_i [SAMPLE_W] : two's-complement input sample
//     abs_o    [SAMPLE_W] : |sample_i|, saturated to 2^(SAMPLE_W-1)-1
// -----------------------------------------------------------------------------
module abs_sat #(
    parameter int SAMPLE_W = 24
) (
    input  logic [SAMPLE_W-1:0] sample_i,
    output logic [SAMPLE_W-1:0] abs_o
);

    localparam logic [SAMPLE_W-1:0] MOST_NEG = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic [SAMPLE_W-1:0] MOST_POS = {1'b0, {(SAMPLE_W-1){1'b1}}};

    always_comb begin
        if (sample_i == MOST_NEG) begin
            abs_o = MOST_POS;
        end else if (sample_i[SAMPLE_W-1]) begin
            abs_o = -sample_i;
        end else begin
            abs_o = sample_i;
        end
    end

endmodule

// File: rtl/pitch_volume_analyser.sv
// -----------------------------------------------------------------------------
// pitch_volume_analyser
//   Audio front-end analyser for one signed PCM channel.
//   Stage 1 captures the sample offered with read_ready; stage 2 updates the
//   zero-crossing period measurement (with hysteresis) and the windowed peak
//   detector, registering all results. Outputs appear two cycles after the
//   sample was offered and hold between strobes.
//   Ports:
//     clk_50      : system clock, rising edge
//     resetn      : synchronous active-low reset
//     left        : signed sample, valid when read_ready=1
//     read_ready  : sample offered this cycle
//     read        : acknowledge, one cycle after each accepted sample
//     pitch       : band code (none/low/mid/high)
//     pitch_valid : one-cycle strobe when pitch/period update
//     period      : last measured period in samples
//     vol         : last window peak >= VOL_TH
//     peak        : last window peak absolute value
//     peak_valid  : one-cycle strobe when vol/peak update
// -----------------------------------------------------------------------------
module pitch_volume_analyser
    import analyser_pkg::*;
#(
    parameter int                  SAMPLE_W = 24,
    parameter int                  CNT_W    = 15,
    parameter int                  HYST     = 0,
    parameter int                  LOW_TH   = 120,
    parameter int                  MID_TH   = 60,
    parameter logic [SAMPLE_W-1:0] VOL_TH   = 24'h00FFFF,
    parameter int                  WIN_LEN  = 800
) (
    input  logic                       clk_50,
    input  logic                       resetn,
    input  logic signed [SAMPLE_W-1:0] left,
    input  logic                       read_ready,
    output logic                       read,
    output logic [1:0]                 pitch,
    output logic                       pitch_valid,
    output logic [CNT_W-1:0]           period,
    output logic                       vol,
    output logic [SAMPLE_W-1:0]        peak,
    output logic                       peak_valid
);

    localparam int               WIN_W    = (WIN_LEN > 2) ? $clog2(WIN_LEN) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [WIN_W-1:0] WIN_LAST = WIN_W'(WIN_LEN - 1);

    // Capture stage
    logic signed [SAMPLE_W-1:0] left_q;
    logic                       valid_q;

    // Period path
    logic             pos_q, pos_d;
    logic             armed_q, armed_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    pitch_e           pitch_q, pitch_d;
    logic             pitch_valid_q, pitch_valid_d;

    // Volume path
    logic [SAMPLE_W-1:0] abs_s;
    logic [SAMPLE_W-1:0] win_max;
    logic [SAMPLE_W-1:0] acc_q, acc_d;
    logic [SAMPLE_W-1:0] peak_q, peak_d;
    logic [WIN_W-1:0]    win_q, win_d;
    logic                vol_q, vol_d;
    logic                peak_valid_q, peak_valid_d;

    logic pos_set;
    logic pos_clr;

    abs_sat #(.SAMPLE_W(SAMPLE_W)) u_abs_sat (
        .sample_i (left_q),
        .abs_o    (abs_s)
    );

    // Hysteresis band: at or above +HYST is positive, at or below -HYST-1 is
    // negative, anything in between keeps the previous polarity.
    assign pos_set = (int'(left_q) >= HYST);
    assign pos_clr = (int'(left_q) <= -HYST - 1);

    // Peak including the sample being processed, so the window's last sample
    // takes part in its own window.
    assign win_max = (abs_s > acc_q) ? abs_s : acc_q;

    // NOTE: every variable driven here gets a default first, so no path can
    // leave it unassigned and infer a latch; the strobes default to 0.
    always_comb begin
        pos_d         = pos_q;
        armed_d       = armed_q;
        cnt_d         = cnt_q;
        period_d      = period_q;
        pitch_d       = pitch_q;
        pitch_valid_d = 1'b0;
        acc_d         = acc_q;
        win_d         = win_q;
        peak_d        = peak_q;
        vol_d         = vol_q;
        peak_valid_d  = 1'b0;

        if (valid_q) begin
            if (pos_set) begin
                pos_d = 1'b1;
            end else if (pos_clr) begin
                pos_d = 1'b0;
            end

            if (!pos_q && pos_set) begin
                // Rising crossing; it takes precedence over a coincident timeout.
                cnt_d   = CNT_W'(1);
                armed_d = 1'b1;
                if (armed_q) begin
                    period_d      = cnt_q;
                    pitch_d       = classify_pitch(int'(cnt_q), LOW_TH, MID_TH);
                    pitch_valid_d = 1'b1;
                end
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + CNT_W'(1);
                // Report the timeout only on the sample that reaches saturation;
                // once saturated the counter sticks and stays silent.
                if (cnt_q == CNT_MAX - CNT_W'(1)) begin
                    period_d      = CNT_MAX;
                    pitch_d       = PITCH_NONE;
                    pitch_valid_d = 1'b1;
                    armed_d       = 1'b0;
                end
            end

            if (win_q == WIN_LAST) begin
                peak_d       = win_max;
                vol_d        = (win_max >= VOL_TH);
                peak_valid_d = 1'b1;
                acc_d        = '0;
                win_d        = '0;
            end else begin
                acc_d = win_max;
                win_d = win_q + WIN_W'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every register
    // samples its next value from the same pre-edge state.
    always_ff @(posedge clk_50) begin
        if (!resetn) begin
            left_q        <= '0;
            valid_q       <= 1'b0;
            pos_q         <= 1'b0;
            armed_q       <= 1'b0;
            cnt_q         <= '0;
            period_q      <= '0;
            pitch_q       <= PITCH_NONE;
            pitch_valid_q <= 1'b0;
            acc_q         <= '0;
            win_q         <= '0;
            peak_q        <= '0;
            vol_q         <= 1'b0;
            peak_valid_q  <= 1'b0;
        end else begin
            valid_q <= read_ready;
            if (read_ready) begin
                left_q <= left;
            end
            pos_q         <= pos_d;
            armed_q       <= armed_d;
            cnt_q         <= cnt_d;
            period_q      <= period_d;
            pitch_q       <= pitch_d;
            pitch_valid_q <= pitch_valid_d;
            acc_q         <= acc_d;
            win_q         <= win_d;
            peak_q        <= peak_d;
            vol_q         <= vol_d;
            peak_valid_q  <= peak_valid_d;
        end
    end

    assign read        = valid_q;
    assign pitch       = pitch_q;
    assign pitch_valid = pitch_valid_q;
    assign period      = period_q;
    assign vol         = vol_q;
    assign peak        = peak_q;
    assign peak_valid  = peak_valid_q;

endmodule
